// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg
//   Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   if_entry_t    : {pc, instr} pair buffered toward decode (default widths)
//   INSTR_BYTES   : sequential PC increment
package if_fetch_unit_pkg;

    localparam int unsigned IF_XLEN     = 32;
    localparam int unsigned IF_ILEN     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// if_fifo
//   Small circular buffer of fetch entries.
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : empties the buffer; wins over push and pop
//   push, push_data   : write one entry at the tail
//   pop               : drop the head entry (ignored when empty)
//   full, empty, count: occupancy
//   head              : entry at the head (valid when !empty)
module if_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = if_entry_t,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && !empty;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                entries_d[wr_ptr_q] = push_data;
                wr_ptr_d            = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = entries_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Fetch stage: reads instructions at the current PC with a single
//   outstanding req/ack transaction, buffers {pc, instr} toward decode and
//   steers the PC register (sequential advance or redirect).
//   clk, rst                  : clock, asynchronous active-high reset
//   pc                        : current PC register value
//   pc_ld, pc_next            : PC register load strobe / value (combinational)
//   redirect_valid/pc         : one-cycle redirect request and target
//   imem_req/addr             : registered read request toward memory
//   imem_ack/rdata            : read completion and data
//   id_valid/ready/pc/instr   : head of the decode buffer, valid/ready handshake
//
//   state | meaning
//   IDLE  | no transaction outstanding; issue at pc when buffer has room
//   WAIT  | request outstanding; response will be buffered
//   DRAIN | request outstanding after a redirect; response will be dropped
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN  = IF_XLEN,
    parameter int unsigned ILEN  = IF_ILEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ld,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    entry_t           push_entry;
    entry_t           head_entry;

    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] seq_next_pc;
    logic [XLEN-1:0] addr_plus4;

    // Redirect targets are forced to word alignment.
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign seq_next_pc     = pc + XLEN'(INSTR_BYTES);
    assign addr_plus4      = addr_q + XLEN'(INSTR_BYTES);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pc_ld      = 1'b0;
        pc_next    = seq_next_pc;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;

        if (redirect_valid) begin
            pc_ld      = 1'b1;
            pc_next    = redirect_target;
            fifo_clear = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // Room is judged on occupancy before this cycle's pop, so an
                // accepted response can never find the buffer full.
                if (!redirect_valid && (fifo_count < CNT_W'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!redirect_valid) begin
                        fifo_push = !fifo_full || fifo_pop;
                        pc_ld     = 1'b1;
                        pc_next   = addr_plus4;
                    end
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Never load the PC register while the stage is held in reset.
        if (rst) begin
            pc_ld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign push_entry = '{pc: addr_q, instr: imem_rdata};
    assign fifo_pop   = id_valid && id_ready;

    if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head_entry)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = !fifo_empty;
    assign id_pc     = head_entry.pc;
    assign id_instr  = head_entry.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_ld;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    if_fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_ld          (pc_ld),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference: buffered entries, the one outstanding read, and its fate.
    ent_t        q[$];
    bit          m_out;
    bit          m_drain;
    logic [31:0] m_addr;
    int          m_wait;
    int          m_lat;
    int          lat = 1;
    bit          rand_lat = 1'b0;

    logic        s_req, s_pc_ld, s_valid;
    logic [31:0] s_addr, s_pc_next, s_idpc, s_idinstr;
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    bit          prev_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_out    = 1'b0;
        m_drain  = 1'b0;
        m_wait   = 0;
        prev_req = 1'b0;
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          ack;
        bit          e_ld;
        bit          e_valid;
        bit          pop;
        bit          issue;
        logic [31:0] e_next;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        ack            = 1'b0;
        if (m_out) begin
            m_wait++;
            ack = (m_wait >= m_lat);
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(m_addr) : $urandom();
        #1;
        e_valid = (q.size() > 0);
        if (rv) begin
            e_ld   = 1'b1;
            e_next = {rpc[31:2], 2'b00};
        end else if (ack && !m_drain) begin
            e_ld   = 1'b1;
            e_next = m_addr + 32'd4;
        end else begin
            e_ld   = 1'b0;
            e_next = pc + 32'd4;
        end
        assert (!(imem_ack && !imem_req)) else $error("protocol: imem_ack with no request outstanding");
        chk("imem_req", imem_req, m_out);
        if (m_out) chk("imem_addr", imem_addr, m_addr);
        chk("id_valid", id_valid, e_valid);
        if (e_valid) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_instr", id_instr, q[0].instr);
        end
        chk("pc_ld", pc_ld, e_ld);
        if (e_ld) chk("pc_next", pc_next, e_next);
        s_req     = imem_req;
        s_addr    = imem_addr;
        s_pc_ld   = pc_ld;
        s_pc_next = pc_next;
        s_valid   = id_valid;
        s_idpc    = id_pc;
        s_idinstr = id_instr;
        if (imem_req && !prev_req) req_log.push_back(imem_addr);
        prev_req = imem_req;
        if (id_valid && rdy) pop_log.push_back(id_pc);
        pop = e_valid && rdy;
        @(posedge clk);
        #1;
        if (rv) begin
            q.delete();
            if (m_out) begin
                if (ack) m_out = 1'b0;
                else     m_drain = 1'b1;
            end
        end else begin
            issue = !m_out && (q.size() < DEPTH);
            if (pop) void'(q.pop_front());
            if (m_out && ack) begin
                if (!m_drain) q.push_back('{m_addr, mem_word(m_addr)});
                m_out = 1'b0;
            end else if (issue) begin
                m_out   = 1'b1;
                m_drain = 1'b0;
                m_addr  = pc;
                m_wait  = 0;
                m_lat   = rand_lat ? int'($urandom_range(1, 4)) : lat;
            end
        end
        if (e_ld) pc = e_next;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        imem_ack       = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rst imem_req", imem_req, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst id_valid", id_valid, 0);
        chk("rst pc_ld", pc_ld, 0);
        redirect_valid = 1'b0;
        model_clear();
        pc = start_pc;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = mem_word(m_addr);
        #1;
        chk("pre-rst pc_ld", pc_ld, 1);
        chk("pre-rst id_valid", id_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async imem_req", imem_req, 0);
        chk("async id_valid", id_valid, 0);
        chk("async pc_ld", pc_ld, 0);
        imem_ack = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post-rst id_valid", id_valid, 0);
    endtask

    initial begin
        // Straight-line fetch, single-cycle memory, decode always ready.
        lat = 1;
        do_reset(32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("t1 no req in decide cycle", s_req, 0);
        step(1'b0, 32'h0, 1'b1);
        chk("t1 first req", s_req, 1);
        chk("t1 pc_next on ack", s_pc_next, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        chk("t1 instr@0", s_idinstr, 32'h5A5A_A5A5);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t1 instr@4", s_idinstr, 32'h2287_4361);
        step(1'b0, 32'h0, 1'b1);
        chk("t1 req count", 32'(req_log.size()), 3);
        for (int i = 0; i < req_log.size() && i < 3; i++)
            chk("t1 req addr", req_log[i], 32'(i * 4));
        chk("t1 pop count", 32'(pop_log.size()), 2);
        for (int i = 0; i < pop_log.size() && i < 2; i++)
            chk("t1 pop pc", pop_log[i], 32'(i * 4));

        // Backpressure: buffer fills at two entries, no third request.
        do_reset(32'h0);
        repeat (8) step(1'b0, 32'h0, 1'b0);
        chk("t2 req count full", 32'(req_log.size()), 2);
        chk("t2 head valid", s_valid, 1);
        chk("t2 head pc", s_idpc, 32'h0);
        chk("t2 no req while full", s_req, 0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("t2 pop count", 32'(pop_log.size()), 1);
        if (pop_log.size() > 0) chk("t2 popped pc", pop_log[0], 32'h0);
        chk("t2 resume req count", 32'(req_log.size()), 3);
        if (req_log.size() > 2) chk("t2 resume addr", req_log[2], 32'h8);

        // Redirect during a slow read: flush, drain the stale response.
        do_reset(32'h0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        lat = 3;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        chk("t3 redirect pc_ld", s_pc_ld, 1);
        chk("t3 redirect pc_next", s_pc_next, 32'h100);
        step(1'b0, 32'h0, 1'b0);
        chk("t3 flushed", s_valid, 0);
        chk("t3 stale ack no pc_ld", s_pc_ld, 0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("t3 refetch req", s_req, 1);
        chk("t3 refetch addr", s_addr, 32'h100);
        lat = 1;

        // Redirect coincident with ack, unaligned target.
        do_reset(32'h0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0203, 1'b1);
        chk("t4 pc_next aligned", s_pc_next, 32'h200);
        step(1'b0, 32'h0, 1'b1);
        chk("t4 no push", s_valid, 0);
        step(1'b0, 32'h0, 1'b1);
        chk("t4 next addr", s_addr, 32'h200);

        // PC wrap at top of address space.
        do_reset(32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t5 wrap pc_ld", s_pc_ld, 1);
        chk("t5 wrap pc_next", s_pc_next, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("t5 head pc", s_idpc, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        chk("t5 wrapped addr", s_addr, 32'h0);

        // Asynchronous reset while a read is outstanding.
        do_reset(32'h0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        reset_mid_wait();
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Randomised traffic against the reference.
        do_reset({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        rand_lat = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 3) != 0);
        end
        rand_lat = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
